// File: rtl/relogio_ctrl.sv
// Time-set and tick controller for the HH:MM:SS counter: 1 Hz tick prescaler,
// hours/minutes edit FSM with blink and inactivity timeout, and a one-cycle load strobe.
module relogio_ctrl #(
    parameter int DIV_TICK  = 50_000_000,
    parameter int BLINK_DIV = 25_000_000,
    parameter int TIMEOUT_S = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [4:0] hora_atual,
    input  logic [5:0] min_atual,
    output logic       tick_en,
    output logic       load,
    output logic [4:0] hora_set,
    output logic [5:0] min_set,
    output logic [5:0] seg_set,
    output logic [1:0] modo,
    output logic       blink
);

    localparam int PW = (DIV_TICK > 1) ? $clog2(DIV_TICK) : 1;
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam int TW = $clog2(TIMEOUT_S + 1);

    localparam logic [PW-1:0] P_LAST = PW'(DIV_TICK - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_S - 1);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        SET_H = 2'b01,
        SET_M = 2'b10
    } state_t;

    state_t        state_reg;
    logic [PW-1:0] pcnt_reg;
    logic [BW-1:0] bcnt_reg;
    logic [TW-1:0] tcnt_reg;
    logic          tick_en_reg;
    logic          load_reg;
    logic          blink_reg;
    logic [4:0]    hora_set_reg;
    logic [5:0]    min_set_reg;
    logic          sec_pulse;

    assign sec_pulse = (pcnt_reg == P_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= RUN;
            pcnt_reg     <= '0;
            bcnt_reg     <= '0;
            tcnt_reg     <= '0;
            tick_en_reg  <= 1'b0;
            load_reg     <= 1'b0;
            blink_reg    <= 1'b0;
            hora_set_reg <= '0;
            min_set_reg  <= '0;
        end else begin
            pcnt_reg    <= sec_pulse ? '0 : pcnt_reg + 1'b1;
            tick_en_reg <= 1'b0;
            load_reg    <= 1'b0;

            case (state_reg)
                RUN: begin
                    blink_reg   <= 1'b0;
                    bcnt_reg    <= '0;
                    tcnt_reg    <= '0;
                    tick_en_reg <= sec_pulse;
                    if (btn_mode) begin
                        state_reg    <= SET_H;
                        hora_set_reg <= hora_atual;
                        min_set_reg  <= min_atual;
                        blink_reg    <= 1'b1;
                    end
                end

                SET_H, SET_M: begin
                    if (bcnt_reg == B_LAST) begin
                        bcnt_reg  <= '0;
                        blink_reg <= ~blink_reg;
                    end else begin
                        bcnt_reg <= bcnt_reg + 1'b1;
                    end

                    // Mode has priority over increment; any press restarts the timeout.
                    if (btn_mode) begin
                        tcnt_reg <= '0;
                        bcnt_reg <= '0;
                        if (state_reg == SET_H) begin
                            state_reg <= SET_M;
                            blink_reg <= 1'b1;
                        end else begin
                            state_reg <= RUN;
                            blink_reg <= 1'b0;
                            load_reg  <= 1'b1;
                            pcnt_reg  <= '0;
                        end
                    end else if (btn_inc) begin
                        tcnt_reg <= '0;
                        if (state_reg == SET_H)
                            hora_set_reg <= (hora_set_reg >= 5'd23) ? 5'd0 : hora_set_reg + 5'd1;
                        else
                            min_set_reg <= (min_set_reg >= 6'd59) ? 6'd0 : min_set_reg + 6'd1;
                    end else if (sec_pulse) begin
                        if (tcnt_reg == T_LAST) begin
                            state_reg <= RUN;
                            blink_reg <= 1'b0;
                            bcnt_reg  <= '0;
                            tcnt_reg  <= '0;
                        end else begin
                            tcnt_reg <= tcnt_reg + 1'b1;
                        end
                    end
                end

                default: state_reg <= RUN;
            endcase
        end
    end

    assign tick_en  = tick_en_reg;
    assign load     = load_reg;
    assign hora_set = hora_set_reg;
    assign min_set  = min_set_reg;
    assign seg_set  = 6'd0;
    assign modo     = state_reg;
    assign blink    = blink_reg;

endmodule

// File: tb/tb_relogio_ctrl.sv
// Directed bench for relogio_ctrl with a load scoreboard fed at confirm time.
module tb_relogio_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_mode;
    logic       btn_inc;
    logic [4:0] hora_atual;
    logic [5:0] min_atual;
    logic       tick_en;
    logic       load;
    logic [4:0] hora_set;
    logic [5:0] min_set;
    logic [5:0] seg_set;
    logic [1:0] modo;
    logic       blink;

    int passed = 0;
    int total  = 0;
    int loads_seen = 0;
    logic [10:0] load_q[$];

    relogio_ctrl #(.DIV_TICK(4), .BLINK_DIV(2), .TIMEOUT_S(3)) dut (
        .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .hora_atual(hora_atual), .min_atual(min_atual),
        .tick_en(tick_en), .load(load), .hora_set(hora_set), .min_set(min_set),
        .seg_set(seg_set), .modo(modo), .blink(blink)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic m, input logic i);
        btn_mode = m;
        btn_inc  = i;
        step();
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
    endtask

    // Scoreboard: every load strobe must match an expected {hora,min} pushed at confirm.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && load === 1'b1) begin
            loads_seen++;
            total++;
            if (load_q.size() == 0) begin
                $error("FAIL load_unexpected observed=%0d/%0d expected=none", hora_set, min_set);
            end else begin
                logic [10:0] e;
                e = load_q.pop_front();
                assert ({hora_set, min_set} === e) passed++;
                else $error("FAIL load_value observed=%0d:%0d expected=%0d:%0d",
                            hora_set, min_set, e[10:6], e[5:0]);
            end
        end
    end

    initial begin
        rst_n = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
        hora_atual = 5'd23; min_atual = 6'd59;

        // 1. reset state and free-running tick
        repeat (3) step();
        chk("rst_modo", modo, 0);
        chk("rst_outs", {tick_en, load, blink, hora_set, min_set}, 0);
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk($sformatf("t1_tick_c%0d", k), tick_en, (k % 4 == 0));
        end
        chk("t1_modo", modo, 0);
        chk("t1_load", load, 0);

        // 2. field wrap and confirm
        press(1, 0);
        chk("t2_modo_seth", modo, 1);
        chk("t2_capture", {hora_set, min_set}, {5'd23, 6'd59});
        chk("t2_blink_on", blink, 1);
        press(0, 1);
        chk("t2_hora_wrap", hora_set, 0);
        press(1, 0);
        chk("t2_modo_setm", modo, 2);
        press(0, 1);
        press(0, 1);
        chk("t2_min", min_set, 1);
        load_q.push_back({5'd0, 6'd1});
        press(1, 0);
        chk("t2_load_hi", load, 1);
        chk("t2_modo_run", modo, 0);
        chk("t2_seg", seg_set, 0);
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k == 1) chk("t2_load_lo", load, 0);
            chk($sformatf("t2_tick_c%0d", k), tick_en, (k == 4));
        end

        // 3. minute wrap, blink cadence and restart
        hora_atual = 5'd5; min_atual = 6'd59;
        press(1, 0);
        chk("t3_blink_entry", blink, 1);
        step();
        chk("t3_blink_hold", blink, 1);
        step();
        chk("t3_blink_toggle", blink, 0);
        press(1, 0);
        chk("t3_blink_restart", blink, 1);
        press(0, 1);
        chk("t3_min_wrap", min_set, 0);
        chk("t3_hora_keep", hora_set, 5);
        load_q.push_back({5'd5, 6'd0});
        press(1, 0);
        chk("t3_load_hi", load, 1);

        // 4. timeout back to RUN without load
        hora_atual = 5'd12; min_atual = 6'd34;
        step();
        press(1, 0);
        chk("t4_modo_seth", modo, 1);
        repeat (12) step();
        chk("t4_modo_run", modo, 0);
        chk("t4_blink_off", blink, 0);
        chk("t4_hold", {hora_set, min_set}, {5'd12, 6'd34});

        // 5. simultaneous mode and increment
        press(1, 0);
        press(0, 1);
        chk("t5_hora_inc", hora_set, 13);
        press(1, 1);
        chk("t5_modo", modo, 2);
        chk("t5_hora_keep", hora_set, 13);

        // 6. reset while editing minutes
        press(0, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t6_modo", modo, 0);
        chk("t6_load", load, 0);
        chk("t6_fields", {hora_set, min_set}, 0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("t6_tick_c%0d", k), tick_en, (k == 4));
        end

        step();
        chk("sb_loads", loads_seen, 2);
        chk("sb_empty", load_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
